// File: rtl/piano_pkg.sv
// Shared message format, source ids and arbiter state encoding for the
// note-message path between keyboard/autoplay and the tone player.
package piano_pkg;

    localparam int MSG_W       = 8;
    localparam int NOTE_W      = 7;
    localparam int NOTE_ON_BIT = 7;

    localparam logic SRC_KB = 1'b0;
    localparam logic SRC_AP = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    function automatic logic is_note_on(input logic [MSG_W-1:0] msg);
        return msg[NOTE_ON_BIT];
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Small first-word-fall-through FIFO; dout always shows the head entry.
// The caller guarantees push only when there is room (or a same-cycle pop).
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/msg_arbiter.sv
// Merges keyboard (priority) and autoplay note streams into the tone player,
// pacing issues with a fixed gap and muting autoplay note-ons under live play.
module msg_arbiter
    import piano_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kb_valid,
    input  logic [MSG_W-1:0]  kb_msg,
    input  logic              ap_valid,
    input  logic [MSG_W-1:0]  ap_msg,
    output logic              ap_ready,
    output logic              out_valid,
    output logic [MSG_W-1:0]  out_msg,
    output logic              out_src,
    output logic [NOTE_W-1:0] cur_note,
    output logic              kb_active,
    output logic              kb_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP + 1);

    arb_state_t       state;
    logic [GW-1:0]    gap_cnt;

    logic             kb_push, kb_pop;
    logic             ap_push, ap_pop;
    logic [MSG_W-1:0] kb_head, ap_head;
    logic [CW-1:0]    kb_count, ap_count;
    logic             kb_nonempty, ap_nonempty;
    logic             ap_discard;

    assign kb_nonempty = (kb_count != '0);
    assign ap_nonempty = (ap_count != '0);
    assign ap_discard  = is_note_on(ap_head) && kb_active;

    // Keyboard cannot stall: a full FIFO only accepts if its head leaves now.
    assign kb_push  = kb_valid && ((kb_count < CW'(DEPTH)) || kb_pop);
    assign ap_ready = (ap_count < CW'(DEPTH));
    assign ap_push  = ap_valid && ap_ready;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs can leave it unassigned and infer a latch.
    always_comb begin
        kb_pop = 1'b0;
        ap_pop = 1'b0;
        if (state == ARB_IDLE) begin
            if (kb_nonempty)      kb_pop = 1'b1;
            else if (ap_nonempty) ap_pop = 1'b1;
        end
    end

    msg_fifo #(.WIDTH(MSG_W), .DEPTH(DEPTH)) u_kb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kb_push),
        .din   (kb_msg),
        .pop   (kb_pop),
        .dout  (kb_head),
        .count (kb_count)
    );

    msg_fifo #(.WIDTH(MSG_W), .DEPTH(DEPTH)) u_ap_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ap_push),
        .din   (ap_msg),
        .pop   (ap_pop),
        .dout  (ap_head),
        .count (ap_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_src   <= 1'b0;
            cur_note  <= '0;
            kb_active <= 1'b0;
            kb_ovf    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (kb_valid && !kb_push) kb_ovf <= 1'b1;

            case (state)
                ARB_IDLE: begin
                    if (kb_nonempty) begin
                        out_msg   <= kb_head;
                        out_src   <= SRC_KB;
                        state     <= ARB_ISSUE;
                        kb_active <= is_note_on(kb_head);
                        if (is_note_on(kb_head)) cur_note <= kb_head[NOTE_W-1:0];
                    end else if (ap_nonempty && !ap_discard) begin
                        out_msg <= ap_head;
                        out_src <= SRC_AP;
                        state   <= ARB_ISSUE;
                        if (is_note_on(ap_head)) cur_note <= ap_head[NOTE_W-1:0];
                    end
                end
                ARB_ISSUE: begin
                    out_valid <= 1'b1;
                    gap_cnt   <= GW'(GAP - 1);
                    state     <= ARB_GAP;
                end
                ARB_GAP: begin
                    if (gap_cnt == '0) state <= ARB_IDLE;
                    else               gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_arbiter.sv
// Scoreboard bench for msg_arbiter: a queue-based reference model predicts
// each issued message; a negedge monitor compares whatever the DUT presents.
module tb_msg_arbiter;
    import piano_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_valid = 1'b0;
    logic [7:0] kb_msg = '0;
    logic       ap_valid = 1'b0;
    logic [7:0] ap_msg = '0;
    logic       ap_ready, out_valid, out_src, kb_active, kb_ovf;
    logic [7:0] out_msg;
    logic [6:0] cur_note;

    msg_arbiter #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .kb_valid  (kb_valid),
        .kb_msg    (kb_msg),
        .ap_valid  (ap_valid),
        .ap_msg    (ap_msg),
        .ap_ready  (ap_ready),
        .out_valid (out_valid),
        .out_msg   (out_msg),
        .out_src   (out_src),
        .cur_note  (cur_note),
        .kb_active (kb_active),
        .kb_ovf    (kb_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Reference model: per-source queues, an arbiter busy window, voice state.
    typedef struct {
        logic [7:0] msg;
        logic       src;
        logic [6:0] note;
        logic       act;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_kbq[$];
    logic [7:0] m_apq[$];
    int         m_busy = 0;
    logic [6:0] m_note = '0;
    logic       m_act = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_kb_n, m_ap_n;
    bit         m_kb_popped;
    logic [7:0] m_msg;

    always @(posedge clk) begin
        if (rst) begin
            m_kbq.delete();
            m_apq.delete();
            exp_q.delete();
            m_busy = 0;
            m_note = '0;
            m_act  = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_kb_n = m_kbq.size();
            m_ap_n = m_apq.size();
            m_kb_popped = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (m_kb_n > 0) begin
                m_msg = m_kbq.pop_front();
                m_kb_popped = 1'b1;
                m_act = m_msg[7];
                if (m_msg[7]) m_note = m_msg[6:0];
                exp_q.push_back('{m_msg, 1'b0, m_note, m_act});
                m_busy = GAP + 1;
            end else if (m_ap_n > 0) begin
                m_msg = m_apq.pop_front();
                if (!(m_msg[7] && m_act)) begin
                    if (m_msg[7]) m_note = m_msg[6:0];
                    exp_q.push_back('{m_msg, 1'b1, m_note, m_act});
                    m_busy = GAP + 1;
                end
            end
            if (kb_valid) begin
                if (m_kb_n < DEPTH || m_kb_popped) m_kbq.push_back(kb_msg);
                else m_ovf = 1'b1;
            end
            if (ap_valid && m_ap_n < DEPTH) m_apq.push_back(ap_msg);
        end
    end

    // Monitor: compares every presented message and the status outputs.
    int   pulse_cyc[$];
    exp_t e;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (out_valid) begin
                pulse_cyc.push_back(cyc);
                check("pulse_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_msg", out_msg, e.msg);
                    check("out_src", out_src, e.src);
                    check("issue_cur_note", cur_note, e.note);
                    check("issue_kb_active", kb_active, e.act);
                end
            end
            check("ap_ready", ap_ready, m_apq.size() < DEPTH);
            check("kb_ovf", kb_ovf, m_ovf);
            check("kb_active", kb_active, m_act);
            check("cur_note", cur_note, m_note);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_kb(input logic [7:0] m);
        kb_valid = 1'b1;
        kb_msg   = m;
        tick();
        kb_valid = 1'b0;
    endtask

    task automatic send_ap(input logic [7:0] m);
        ap_valid = 1'b1;
        ap_msg   = m;
        tick();
        ap_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((m_kbq.size() + m_apq.size() + exp_q.size() + m_busy) != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_time", n < budget, 1);
    endtask

    task automatic wait_pulses(input int count, input int budget);
        int n = 0;
        while (pulse_cyc.size() < count && n < budget) begin
            tick();
            n++;
        end
        check("pulse_in_time", pulse_cyc.size() >= count, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int base;

        // Reset state
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_src", out_src, 0);
        check("rst_cur_note", cur_note, 0);
        check("rst_kb_active", kb_active, 0);
        check("rst_kb_ovf", kb_ovf, 0);
        check("rst_ap_ready", ap_ready, 1);
        repeat (6) tick();

        // Keyboard latency: sampled at edge N, visible after edge N+2
        pulse_cyc.delete();
        kb_valid = 1'b1;
        kb_msg   = 8'h85;
        tick();
        n0 = cyc;
        kb_valid = 1'b0;
        wait_pulses(1, 20);
        if (pulse_cyc.size() > 0) check("kb_latency", pulse_cyc[0], n0 + 2);
        check("t1_cur_note", cur_note, 5);
        check("t1_kb_active", kb_active, 1);
        send_kb(8'h05);
        wait_quiet(100);

        // Autoplay back-to-back: three pulses GAP+2 apart
        pulse_cyc.delete();
        send_ap(8'h83);
        send_ap(8'h84);
        send_ap(8'h03);
        wait_pulses(3, 120);
        if (pulse_cyc.size() >= 3) begin
            check("ap_spacing_1", pulse_cyc[1] - pulse_cyc[0], GAP + 2);
            check("ap_spacing_2", pulse_cyc[2] - pulse_cyc[1], GAP + 2);
        end
        wait_quiet(100);
        check("ap_last_note", cur_note, 4);

        // Simultaneous kb/ap: keyboard wins, autoplay note-on muted
        pulse_cyc.delete();
        kb_valid = 1'b1; kb_msg = 8'h81;
        ap_valid = 1'b1; ap_msg = 8'h82;
        tick();
        kb_valid = 1'b0; ap_valid = 1'b0;
        wait_quiet(100);
        repeat (GAP + 4) tick();
        check("sim_one_pulse", pulse_cyc.size(), 1);
        check("sim_cur_note", cur_note, 1);
        send_kb(8'h01);
        wait_quiet(100);
        check("sim_kb_off", kb_active, 0);
        check("sim_two_pulses", pulse_cyc.size(), 2);

        // Live override: note-on dropped, note-off forwarded
        send_kb(8'h81);
        wait_quiet(100);
        pulse_cyc.delete();
        send_ap(8'h90);
        send_ap(8'h10);
        wait_quiet(100);
        check("ovr_pulses", pulse_cyc.size(), 1);
        check("ovr_cur_note", cur_note, 1);
        check("ovr_src", out_src, 1);
        check("ovr_msg", out_msg, 8'h10);

        // Keyboard overflow while the arbiter sits in its gap
        pulse_cyc.delete();
        send_ap(8'h07);
        wait_pulses(1, 20);
        for (int i = 0; i < 8; i++) send_kb(8'h20 + 8'(i));
        check("ovf_set", kb_ovf, 1);
        wait_quiet(200);
        check("ovf_pulses", pulse_cyc.size(), 5);
        check("ovf_sticky", kb_ovf, 1);

        // Reset mid-gap with autoplay entries queued
        send_kb(8'h00);
        wait_quiet(100);
        pulse_cyc.delete();
        for (int i = 0; i < 4; i++) send_ap(8'h08 + 8'(i));
        wait_pulses(1, 20);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_msg", out_msg, 0);
        check("mid_rst_out_src", out_src, 0);
        check("mid_rst_ap_ready", ap_ready, 1);
        check("mid_rst_kb_ovf", kb_ovf, 0);
        rst = 1'b0;
        base = pulse_cyc.size();
        repeat (3 * (GAP + 2)) tick();
        check("mid_rst_no_pulses", pulse_cyc.size(), base);

        // Randomized mixed traffic against the model
        for (int i = 0; i < 2000; i++) begin
            kb_valid = ($urandom_range(0, 11) == 0);
            kb_msg   = 8'($urandom);
            ap_valid = ($urandom_range(0, 2) == 0);
            ap_msg   = 8'($urandom);
            tick();
        end
        kb_valid = 1'b0;
        ap_valid = 1'b0;
        wait_quiet(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
